// File: rtl/sumador_serial_nbit_if.sv
// Operand/result bundle for the bit-serial adder.
// The sign-magnitude inputs a_neg/b_neg exist only when SIGN_MAG_IN_EN is defined.
interface sumador_serial_nbit_if #(
  parameter int n = 8
);
  logic         start;
  logic [n-1:0] A;
  logic [n-1:0] B;
`ifdef SIGN_MAG_IN_EN
  logic         a_neg;
  logic         b_neg;
`endif
  logic         busy;
  logic         done;
  logic [n-1:0] suma;
  logic         Cout;

`ifdef SIGN_MAG_IN_EN
  modport master (
    output start, A, B, a_neg, b_neg,
    input  busy, done, suma, Cout
  );
  modport slave (
    input  start, A, B, a_neg, b_neg,
    output busy, done, suma, Cout
  );
`else
  modport master (
    output start, A, B,
    input  busy, done, suma, Cout
  );
  modport slave (
    input  start, A, B,
    output busy, done, suma, Cout
  );
`endif
endinterface

// File: rtl/sumador_serial_nbit.sv
// Bit-serial n-bit adder: one full-adder cell plus a registered carry,
// one operand bit per clock, start/done handshake.
// Optional feature macro: SIGN_MAG_IN_EN -- operands arrive as sign-magnitude
// (a_neg/b_neg) and are converted to two's complement on the accepting edge.
module sumador_serial_nbit #(
  parameter int n = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sumador_serial_nbit_if.slave bus
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Carry of a full-adder cell: majority of the three inputs.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Sum of a full-adder cell: odd parity of the three inputs.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Sign-magnitude to two's complement; a negative zero maps to zero.
  function automatic logic [n-1:0] to_twos(input logic [n-1:0] x, input logic neg);
    logic [n-1:0] r;
    if (neg) begin
      r = ~x + {{(n-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  state_t        state_r;
  logic [n-1:0]  sa_r;
  logic [n-1:0]  sb_r;
  logic [n-1:0]  acc_r;
  logic          carry_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;
  logic          done_r;
  logic [n-1:0]  suma_r;
  logic          cout_r;

  logic          sum_bit_s;
  logic          carry_nxt_s;
  logic          last_bit_s;
  logic [n-1:0]  op_a_s;
  logic [n-1:0]  op_b_s;

  // Full-adder cell on the current LSBs, end-of-operation detect, operand conditioning.
  always_comb begin
    sum_bit_s   = fa_sum(sa_r[0], sb_r[0], carry_r);
    carry_nxt_s = fa_carry(sa_r[0], sb_r[0], carry_r);
    last_bit_s  = (cnt_r == CW'(n - 1));
`ifdef SIGN_MAG_IN_EN
    op_a_s      = to_twos(bus.A, bus.a_neg);
    op_b_s      = to_twos(bus.B, bus.b_neg);
`else
    op_a_s      = bus.A;
    op_b_s      = bus.B;
`endif
  end

  // Control FSM and datapath registers; every output is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sa_r    <= {n{1'b0}};
      sb_r    <= {n{1'b0}};
      acc_r   <= {n{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      suma_r  <= {n{1'b0}};
      cout_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            sa_r    <= op_a_s;
            sb_r    <= op_b_s;
            acc_r   <= {n{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here: no queueing.
          sa_r    <= {1'b0, sa_r[n-1:1]};
          sb_r    <= {1'b0, sb_r[n-1:1]};
          carry_r <= carry_nxt_s;
          acc_r   <= {sum_bit_s, acc_r[n-1:1]};
          cnt_r   <= cnt_r + CW'(1);
          if (last_bit_s) begin
            suma_r  <= {sum_bit_s, acc_r[n-1:1]};
            cout_r  <= carry_nxt_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          // Single-cycle completion pulse; start is ignored in this cycle.
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.suma = suma_r;
  assign bus.Cout = cout_r;

endmodule

// File: tb/tb_sumador_serial_nbit.sv
// Directed self-checking bench for sumador_serial_nbit (n = 8).
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_sumador_serial_nbit;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  sumador_serial_nbit_if #(.n(N)) bus_if ();

  sumador_serial_nbit #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the falling edge after the accepting edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic an, input logic bn);
    @(negedge clk);
    bus_if.A     = a;
    bus_if.B     = b;
`ifdef SIGN_MAG_IN_EN
    bus_if.a_neg = an;
    bus_if.b_neg = bn;
`endif
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.A     = 8'h00;
    bus_if.B     = 8'h00;
  endtask

  // Wait (bounded) for done at falling edges; ok=0 on timeout.
  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.suma, bus_if.Cout} !== 11'b0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b suma=%h Cout=%b, required all 0",
               bus_if.busy, bus_if.done, bus_if.suma, bus_if.Cout);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic ok;
    int   busy_bad;
    busy_bad = 0;
    start_op(8'h25, 8'h13, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      if (bus_if.busy !== 1'b1 || bus_if.done !== 1'b0) busy_bad++;
      @(negedge clk);
    end
    checks++;
    if (busy_bad != 0) begin
      failures++;
      $display("FAIL basic_busy: %0d of %0d RUN cycles wrong, required busy=1 done=0", busy_bad, N);
    end
    checks++;
    if (bus_if.done !== 1'b1 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_latency: done=%b busy=%b after %0d edges, required done=1 busy=0",
               bus_if.done, bus_if.busy, N);
    end
    checks++;
    if (bus_if.suma !== 8'h38 || bus_if.Cout !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum: suma=%h Cout=%b, required 38/0", bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.suma !== 8'h38 || bus_if.Cout !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: done=%b suma=%h Cout=%b, required 0/38/0",
               bus_if.done, bus_if.suma, bus_if.Cout);
    end
    ok = 1'b0;
  endtask

  task automatic test_overflow();
    logic ok;
    start_op(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || bus_if.suma !== 8'h00 || bus_if.Cout !== 1'b1) begin
      failures++;
      $display("FAIL overflow: done_seen=%b suma=%h Cout=%b, required 1/00/1", ok, bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
  endtask

  task automatic test_interference();
    logic ok;
    int   dones;
    start_op(8'h0F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    // start pulse in the middle of RUN
    bus_if.A = 8'hAA; bus_if.B = 8'h55; bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || bus_if.suma !== 8'h10 || bus_if.Cout !== 1'b0) begin
      failures++;
      $display("FAIL interference_run: done_seen=%b suma=%h Cout=%b, required 1/10/0", ok, bus_if.suma, bus_if.Cout);
    end
    // start pulse during the DONE cycle
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0 || bus_if.suma !== 8'h10) begin
      failures++;
      $display("FAIL interference_done: %0d cycles with busy/done activity, suma=%h, required 0 and 10",
               dones, bus_if.suma);
    end
    // a fresh start after returning to IDLE is accepted
    start_op(8'h01, 8'h02, 1'b0, 1'b0);
    checks++;
    if (bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_accept: busy=%b, required 1", bus_if.busy);
    end
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || bus_if.suma !== 8'h03 || bus_if.Cout !== 1'b0) begin
      failures++;
      $display("FAIL restart_result: done_seen=%b suma=%h Cout=%b, required 1/03/0", ok, bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic ok;
    int   dones;
    start_op(8'h5A, 8'h21, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    // now inside the 4th RUN cycle (between t3 and t4); reset between edges
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.busy, bus_if.done, bus_if.suma, bus_if.Cout} !== 11'b0) begin
      failures++;
      $display("FAIL reset_async: busy=%b done=%b suma=%h Cout=%b, required all 0",
               bus_if.busy, bus_if.done, bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0 || bus_if.suma !== 8'h00) begin
      failures++;
      $display("FAIL reset_abort: %0d cycles with busy/done activity, suma=%h, required 0 and 00",
               dones, bus_if.suma);
    end
    start_op(8'h80, 8'h80, 1'b0, 1'b0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || bus_if.suma !== 8'h00 || bus_if.Cout !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_op: done_seen=%b suma=%h Cout=%b, required 1/00/1", ok, bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
  endtask

`ifdef SIGN_MAG_IN_EN
  task automatic test_sign_mag();
    logic ok;
    start_op(8'h05, 8'h03, 1'b1, 1'b0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || bus_if.suma !== 8'hFE || bus_if.Cout !== 1'b0) begin
      failures++;
      $display("FAIL sm_neg5_plus3: done_seen=%b suma=%h Cout=%b, required 1/FE/0", ok, bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
    start_op(8'h05, 8'h07, 1'b1, 1'b0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || bus_if.suma !== 8'h02 || bus_if.Cout !== 1'b1) begin
      failures++;
      $display("FAIL sm_neg5_plus7: done_seen=%b suma=%h Cout=%b, required 1/02/1", ok, bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
    start_op(8'h00, 8'h00, 1'b1, 1'b0);
    wait_done(ok);
    checks++;
    if (ok !== 1'b1 || bus_if.suma !== 8'h00 || bus_if.Cout !== 1'b0) begin
      failures++;
      $display("FAIL sm_neg_zero: done_seen=%b suma=%h Cout=%b, required 1/00/0", ok, bus_if.suma, bus_if.Cout);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.A     = 8'h00;
    bus_if.B     = 8'h00;
`ifdef SIGN_MAG_IN_EN
    bus_if.a_neg = 1'b0;
    bus_if.b_neg = 1'b0;
`endif
    test_reset();
    test_basic();
    test_overflow();
    test_interference();
    test_reset_mid_run();
`ifdef SIGN_MAG_IN_EN
    test_sign_mag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
